// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
//   Groups the fetch stage's signals: the redirect input from EX/WB, the
//   valid/ready handshake towards ID, and the instruction-memory
//   request/response bus.
//
//   master : the fetch unit (drives if_valid, pc_if, inst_if,
//            imem_req_valid and imem_addr)
//   slave  : the surrounding pipeline and memory (drives flush,
//            redirect_pc, id_ready, imem_req_ready, imem_resp_valid
//            and imem_resp_data)
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] pc_if;
  logic [31:0] inst_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    input  flush, redirect_pc, id_ready,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output if_valid, pc_if, inst_if,
    output imem_req_valid, imem_addr
  );

  modport slave (
    output flush, redirect_pc, id_ready,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  if_valid, pc_if, inst_if,
    input  imem_req_valid, imem_addr
  );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage. Holds the PC and issues one instruction-memory
//   request at a time. The returned word is presented to ID as
//   {pc_if, inst_if} with if_valid until ID accepts it. Redirects (flush)
//   reload the PC and, if a response is still in flight, discard it.
//
// Parameters
//   RESET_PC        PC loaded by reset; first fetch address
//
// Ports
//   clock           clock, rising edge
//   reset           synchronous, active-high reset
//   fetch           if_fetch_unit_if.master: flush/redirect_pc, ID
//                   handshake (if_valid, pc_if, inst_if, id_ready) and
//                   imem request/response bus
//   perf_fetch_cnt  (IF_FETCH_PERF_EN only) accepted ID handshakes
//   perf_stall_cnt  (IF_FETCH_PERF_EN only) cycles with if_valid && !id_ready
//
// Optional feature macro: IF_FETCH_PERF_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  if_fetch_unit_if.master fetch
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DISCARD
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;

  // Request accepted by memory this cycle.
  logic req_fire;
  assign req_fire = (state_reg == REQ) && fetch.imem_req_ready;

  // Redirect targets are forced word-aligned; the low two bits are ignored.
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = fetch.redirect_pc[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'h0;
    end else if (fetch.flush) begin
      // Redirect wins over everything. Whether a response is still owed
      // decides between refetching straight away and draining it first.
      pc_reg <= {fetch.redirect_pc[31:2], 2'b00};
      case (state_reg)
        IDLE, HOLD: state_reg <= REQ;
        REQ:        state_reg <= req_fire ? DISCARD : REQ;
        WAIT:       state_reg <= fetch.imem_resp_valid ? REQ : DISCARD;
        DISCARD:    state_reg <= fetch.imem_resp_valid ? REQ : DISCARD;
        default:    state_reg <= IDLE;
      endcase
    end else begin
      case (state_reg)
        IDLE: state_reg <= REQ;
        REQ: begin
          if (req_fire) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (fetch.imem_resp_valid) begin
            inst_reg  <= fetch.imem_resp_data;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (fetch.id_ready) begin
            pc_reg    <= pc_reg + 32'd4;
            state_reg <= REQ;
          end
        end
        DISCARD: begin
          // Stale response: drop it, inst_reg keeps the old word.
          if (fetch.imem_resp_valid) begin
            state_reg <= REQ;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign fetch.if_valid       = (state_reg == HOLD);
  assign fetch.imem_req_valid = (state_reg == REQ);
  assign fetch.imem_addr      = pc_reg;
  assign fetch.pc_if          = pc_reg;
  assign fetch.inst_if        = inst_reg;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_reg <= 32'h0;
      stall_cnt_reg <= 32'h0;
    end else begin
      // A flush in HOLD throws the instruction away, so it is not a handshake.
      if ((state_reg == HOLD) && fetch.id_ready && !fetch.flush) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
      if ((state_reg == HOLD) && !fetch.id_ready) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed scenarios followed by randomized stimulus. A transaction-level
//   model (outstanding/stale/holding flags, PC and held word) predicts every
//   output each cycle; a single compare process checks it on the falling
//   edge. A simple memory answers each accepted request after 1..4 cycles
//   with data = addr ^ KEY and injects stray responses while idle.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  if_fetch_unit_if bus ();

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_fetch_unit #(.RESET_PC(32'h8000_0000)) dut (
    .clock (clock),
    .reset (reset),
    .fetch (bus.master)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ok = 1'b0;
  bit          m_start;   // first cycle after reset: nothing requested yet
  bit          m_out;     // a request was accepted, response not yet seen
  bit          m_stale;   // that outstanding response must be dropped
  bit          m_hold;    // an instruction is presented to ID
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  always @(posedge clock) begin : model
    bit resp_now;
    bit hs;
    if (reset) begin
      m_ok = 1'b1; m_start = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
      m_pc = 32'h8000_0000; m_inst = 32'h0; m_fetch = 32'h0; m_stall = 32'h0;
    end else if (m_ok) begin
      resp_now = bus.imem_resp_valid && m_out;
      hs       = !m_start && !m_out && !m_hold && bus.imem_req_ready;
      if (m_hold && !bus.id_ready) m_stall = m_stall + 32'd1;
      if (bus.flush) begin
        m_pc   = {bus.redirect_pc[31:2], 2'b00};
        m_hold = 1'b0;
        if (resp_now) m_out = 1'b0;
        if (hs)       m_out = 1'b1;
        m_stale = m_out;
      end else begin
        if (m_hold && bus.id_ready) begin
          $display("fetch accepted pc=%h inst=%h", m_pc, m_inst);
          m_pc    = m_pc + 32'd4;
          m_hold  = 1'b0;
          m_fetch = m_fetch + 32'd1;
        end
        if (resp_now) begin
          m_out = 1'b0;
          if (!m_stale) begin
            m_inst = bus.imem_resp_data;
            m_hold = 1'b1;
          end
          m_stale = 1'b0;
        end
        if (hs) m_out = 1'b1;
      end
      m_start = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (m_ok) begin
      chk("if_valid",  {31'h0, bus.if_valid},       {31'h0, m_hold});
      chk("req_valid", {31'h0, bus.imem_req_valid}, {31'h0, !m_start && !m_out && !m_hold});
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("pc_if",     bus.pc_if,     m_pc);
      chk("inst_if",   bus.inst_if,   m_inst);
`ifdef IF_FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, m_fetch);
      chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    end
  end

  // ---------------- memory ----------------
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  int          mem_lat  = 0;     // fixed latency, or random when negative
  bit          spur_en  = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  always @(posedge clock) begin
    if (bus.imem_resp_valid === 1'b1) mem_busy = 1'b0;
    if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
      mem_busy = 1'b1;
      mem_addr = bus.imem_addr;
      mem_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
    end
  end

  always @(negedge clock) begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = $urandom;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_addr ^ KEY;
      end else begin
        mem_cnt--;
      end
    end else if (spur_en && $urandom_range(0, 15) == 0) begin
      bus.imem_resp_valid = 1'b1;
    end
  end

  task automatic wait_for_valid(input string name);
    int k;
    k = 0;
    while (bus.if_valid !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk(name, {31'h0, bus.if_valid}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic [31:0] cnt0;
    logic [31:0] r;
    bus.flush          = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    bus.imem_req_ready = 1'b1;
    reset              = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_if_valid",  {31'h0, bus.if_valid},       32'h0);
    chk("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    chk("rst_pc",        bus.pc_if,                   32'h8000_0000);
    chk("rst_inst",      bus.inst_if,                 32'h0);

    // 1: first fetch at RESET_PC in the 2nd cycle, then +4
    mem_lat = 0;
    reset   = 1'b0;
    @(negedge clock);
    chk("t1_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("t1_addr",      bus.imem_addr,               32'h8000_0000);
    @(negedge clock);
    chk("t1_wait_no_valid", {31'h0, bus.if_valid}, 32'h0);
    @(negedge clock);
    chk("t1_if_valid", {31'h0, bus.if_valid}, 32'h1);
    chk("t1_inst",     bus.inst_if,           32'h9357_9BDF);
    chk("t1_pc",       bus.pc_if,             32'h8000_0000);
    @(negedge clock);
    chk("t1_addr2", bus.imem_addr, 32'h8000_0004);
    bus.id_ready = 1'b0;

    // 2: five stall cycles in HOLD
    wait_for_valid("t2_valid");
    hold_pc   = bus.pc_if;
    hold_inst = bus.inst_if;
    chk("t2_pc",   hold_pc,   32'h8000_0004);
    chk("t2_inst", hold_inst, 32'h9357_9BDB);
`ifdef IF_FETCH_PERF_EN
    cnt0 = perf_stall_cnt;
`else
    cnt0 = 32'h0;
`endif
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", {31'h0, bus.if_valid},       32'h1);
      chk("t2_hold_pc",    bus.pc_if,                   hold_pc);
      chk("t2_hold_inst",  bus.inst_if,                 hold_inst);
      chk("t2_no_req",     {31'h0, bus.imem_req_valid}, 32'h0);
      @(negedge clock);
    end
`ifdef IF_FETCH_PERF_EN
    chk("t2_stall_cnt", perf_stall_cnt, cnt0 + 32'd5);
`endif

    // 3: memory refuses the request for 4 cycles
    bus.id_ready       = 1'b1;
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t3_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
      chk("t3_addr",      bus.imem_addr,               32'h8000_0008);
    end

    // 4: flush while waiting, stale response two cycles after the request
    mem_lat            = 1;
    bus.imem_req_ready = 1'b1;
    @(negedge clock);
    chk("t4_in_wait", {31'h0, bus.imem_req_valid}, 32'h0);
    bus.flush       = 1'b1;
    bus.redirect_pc = 32'h8000_0103;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("t4_discard_valid", {31'h0, bus.if_valid},       32'h0);
    chk("t4_discard_req",   {31'h0, bus.imem_req_valid}, 32'h0);
    chk("t4_pc",            bus.imem_addr,               32'h8000_0100);
    @(negedge clock);
    chk("t4_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("t4_addr",      bus.imem_addr,               32'h8000_0100);
    chk("t4_no_stale",  {31'h0, bus.if_valid},       32'h0);
    mem_lat      = 0;
    bus.id_ready = 1'b0;
    wait_for_valid("t4_valid");
    chk("t4_valid_pc",   bus.pc_if,   32'h8000_0100);
    chk("t4_valid_inst", bus.inst_if, 32'h9357_9ADF);

    // 5: flush in HOLD together with id_ready
`ifdef IF_FETCH_PERF_EN
    cnt0 = perf_fetch_cnt;
`endif
    bus.flush       = 1'b1;
    bus.redirect_pc = 32'h0000_1236;
    bus.id_ready    = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("t5_if_valid", {31'h0, bus.if_valid},       32'h0);
    chk("t5_req",      {31'h0, bus.imem_req_valid}, 32'h1);
    chk("t5_addr",     bus.imem_addr,               32'h0000_1234);
`ifdef IF_FETCH_PERF_EN
    chk("t5_fetch_cnt", perf_fetch_cnt, cnt0);
`endif

    // 6: PC wrap
    bus.flush       = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    bus.id_ready    = 1'b0;
    @(negedge clock);
    bus.flush = 1'b0;
    wait_for_valid("t6_valid");
    chk("t6_pc",   bus.pc_if,   32'hFFFF_FFFC);
    chk("t6_inst", bus.inst_if, 32'hECA8_6423);
    bus.id_ready = 1'b1;
    @(negedge clock);
    chk("t6_req",  {31'h0, bus.imem_req_valid}, 32'h1);
    chk("t6_wrap", bus.imem_addr,               32'h0000_0000);

    // Randomized phase
    mem_lat = -1;
    spur_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      r = $urandom;
      if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
      bus.redirect_pc    = r;
      bus.id_ready       = ($urandom_range(0, 9) < 6);
      bus.imem_req_ready = ($urandom_range(0, 9) < 6);
      @(negedge clock);
    end
    reset     = 1'b0;
    bus.flush = 1'b0;
    repeat (5) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
